// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS control path: FSM states, opcodes
// and the aluOp codes handed to alucontrol.
package mips_pkg;

  typedef enum logic [3:0] {
    ST_BOOT   = 4'd0,
    ST_FETCH  = 4'd1,
    ST_DECODE = 4'd2,
    ST_MEMADR = 4'd3,
    ST_MEMRD  = 4'd4,
    ST_MEMWB  = 4'd5,
    ST_MEMWR  = 4'd6,
    ST_RTEX   = 4'd7,
    ST_RTWB   = 4'd8,
    ST_BEQEX  = 4'd9,
    ST_BNEEX  = 4'd10,
    ST_ADDIEX = 4'd11,
    ST_ADDIWB = 4'd12,
    ST_JEX    = 4'd13,
    ST_HALT   = 4'd14
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_BNE   = 6'd5;
  localparam logic [5:0] OP_ADDI  = 6'd8;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;

  localparam logic [2:0] ALUOP_ADD   = 3'b000;
  localparam logic [2:0] ALUOP_SUB   = 3'b001;
  localparam logic [2:0] ALUOP_FUNCT = 3'b010;

  localparam logic [1:0] SRCB_REGB  = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/main_control.sv
// Multicycle MIPS main control FSM. aluOp is decoded from the next state so the
// registered aluControl in alucontrol lines up with the state that uses it.
module main_control
  import mips_pkg::*;
#(
  parameter bit HALT_ON_ILLEGAL = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       memReady,
  output logic [2:0] aluOp,
  output logic       aluSrcA,
  output logic [1:0] aluSrcB,
  output logic [1:0] pcSrc,
  output logic       pcWrite,
  output logic       pcWriteCond,
  output logic       pcWriteCondNe,
  output logic       iorD,
  output logic       memRead,
  output logic       memWrite,
  output logic       irWrite,
  output logic       memToReg,
  output logic       regDst,
  output logic       regWrite,
  output logic       illegalOp,
  output logic [3:0] state
);

  state_t state_q;
  state_t state_d;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_BOOT;
    else        state_q <= state_d;
  end

  assign state = state_q;

  // NOTE: every always_comb output is given a default first so no path infers a latch.
  always_comb begin
    state_d = ST_FETCH;
    case (state_q)
      ST_BOOT:   state_d = ST_FETCH;
      ST_FETCH:  state_d = memReady ? ST_DECODE : ST_FETCH;
      ST_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_d = ST_MEMADR;
          OP_RTYPE:     state_d = ST_RTEX;
          OP_BEQ:       state_d = ST_BEQEX;
          OP_BNE:       state_d = ST_BNEEX;
          OP_ADDI:      state_d = ST_ADDIEX;
          OP_J:         state_d = ST_JEX;
          default:      state_d = HALT_ON_ILLEGAL ? ST_HALT : ST_FETCH;
        endcase
      end
      ST_MEMADR: state_d = (opcode == OP_LW) ? ST_MEMRD : ST_MEMWR;
      ST_MEMRD:  state_d = memReady ? ST_MEMWB : ST_MEMRD;
      ST_MEMWB:  state_d = ST_FETCH;
      ST_MEMWR:  state_d = memReady ? ST_FETCH : ST_MEMWR;
      ST_RTEX:   state_d = ST_RTWB;
      ST_RTWB:   state_d = ST_FETCH;
      ST_BEQEX:  state_d = ST_FETCH;
      ST_BNEEX:  state_d = ST_FETCH;
      ST_ADDIEX: state_d = ST_ADDIWB;
      ST_ADDIWB: state_d = ST_FETCH;
      ST_JEX:    state_d = ST_FETCH;
      ST_HALT:   state_d = ST_HALT;
      default:   state_d = ST_FETCH;
    endcase
  end

  // Looking one state ahead lets alucontrol's register present aluControl in time.
  always_comb begin
    aluOp = ALUOP_ADD;
    case (state_d)
      ST_RTEX:            aluOp = ALUOP_FUNCT;
      ST_BEQEX, ST_BNEEX: aluOp = ALUOP_SUB;
      default:            aluOp = ALUOP_ADD;
    endcase
  end

  always_comb begin
    aluSrcA       = 1'b0;
    aluSrcB       = SRCB_REGB;
    pcSrc         = PCSRC_ALU;
    pcWrite       = 1'b0;
    pcWriteCond   = 1'b0;
    pcWriteCondNe = 1'b0;
    iorD          = 1'b0;
    memRead       = 1'b0;
    memWrite      = 1'b0;
    irWrite       = 1'b0;
    memToReg      = 1'b0;
    regDst        = 1'b0;
    regWrite      = 1'b0;
    illegalOp     = 1'b0;
    case (state_q)
      ST_FETCH: begin
        memRead = 1'b1;
        aluSrcB = SRCB_FOUR;
        irWrite = memReady;
        pcWrite = memReady;
      end
      ST_DECODE: begin
        aluSrcB = SRCB_IMMSH;
        case (opcode)
          OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_BNE, OP_ADDI, OP_J: illegalOp = 1'b0;
          default: illegalOp = 1'b1;
        endcase
      end
      ST_MEMADR: begin
        aluSrcA = 1'b1;
        aluSrcB = SRCB_IMM;
      end
      ST_MEMRD: begin
        memRead = 1'b1;
        iorD    = 1'b1;
      end
      ST_MEMWB: begin
        regWrite = 1'b1;
        memToReg = 1'b1;
      end
      ST_MEMWR: begin
        memWrite = 1'b1;
        iorD     = 1'b1;
      end
      ST_RTEX:   aluSrcA = 1'b1;
      ST_RTWB: begin
        regWrite = 1'b1;
        regDst   = 1'b1;
      end
      ST_BEQEX: begin
        aluSrcA     = 1'b1;
        pcSrc       = PCSRC_ALUOUT;
        pcWriteCond = 1'b1;
      end
      ST_BNEEX: begin
        aluSrcA       = 1'b1;
        pcSrc         = PCSRC_ALUOUT;
        pcWriteCondNe = 1'b1;
      end
      ST_ADDIEX: begin
        aluSrcA = 1'b1;
        aluSrcB = SRCB_IMM;
      end
      ST_ADDIWB: regWrite = 1'b1;
      ST_JEX: begin
        pcWrite = 1'b1;
        pcSrc   = PCSRC_JUMP;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_main_control.sv
// Scoreboard bench for main_control: stimulus pushes hand-written expected outputs,
// a negedge monitor pops and compares. A second instance covers HALT_ON_ILLEGAL=0.
module tb_main_control;

  typedef struct packed {
    logic [3:0]  st;
    logic [3:0]  st_b;
    logic [2:0]  alu;
    logic [15:0] strb;
  } exp_t;

  // Strobe vector layout: {srcA, srcB[1:0], pcSrc[1:0], pcWrite, pcWriteCond,
  // pcWriteCondNe, iorD, memRead, memWrite, irWrite, memToReg, regDst, regWrite, illegalOp}
  localparam logic [15:0] SRCA    = 16'h8000;
  localparam logic [15:0] SRCB_4  = 16'h2000;
  localparam logic [15:0] SRCB_I  = 16'h4000;
  localparam logic [15:0] SRCB_I2 = 16'h6000;
  localparam logic [15:0] PCS_AO  = 16'h0800;
  localparam logic [15:0] PCS_J   = 16'h1000;
  localparam logic [15:0] PCW     = 16'h0400;
  localparam logic [15:0] PCWC    = 16'h0200;
  localparam logic [15:0] PCWN    = 16'h0100;
  localparam logic [15:0] IORD    = 16'h0080;
  localparam logic [15:0] MR      = 16'h0040;
  localparam logic [15:0] MW      = 16'h0020;
  localparam logic [15:0] IRW     = 16'h0010;
  localparam logic [15:0] M2R     = 16'h0008;
  localparam logic [15:0] RDST    = 16'h0004;
  localparam logic [15:0] RW      = 16'h0002;
  localparam logic [15:0] ILL     = 16'h0001;
  localparam logic [15:0] F_WAIT  = MR | SRCB_4;
  localparam logic [15:0] F_RDY   = MR | SRCB_4 | IRW | PCW;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode;
  logic       memReady;

  logic [2:0] aluOp;
  logic       aluSrcA;
  logic [1:0] aluSrcB, pcSrc;
  logic       pcWrite, pcWriteCond, pcWriteCondNe, iorD, memRead, memWrite;
  logic       irWrite, memToReg, regDst, regWrite, illegalOp;
  logic [3:0] state;

  logic [2:0] aluOp_b;
  logic       aluSrcA_b;
  logic [1:0] aluSrcB_b, pcSrc_b;
  logic       pcWrite_b, pcWriteCond_b, pcWriteCondNe_b, iorD_b, memRead_b, memWrite_b;
  logic       irWrite_b, memToReg_b, regDst_b, regWrite_b, illegalOp_b;
  logic [3:0] state_b;

  exp_t sb[$];
  exp_t e;
  logic [15:0] act;
  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  main_control #(.HALT_ON_ILLEGAL(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .memReady(memReady),
    .aluOp(aluOp), .aluSrcA(aluSrcA), .aluSrcB(aluSrcB), .pcSrc(pcSrc),
    .pcWrite(pcWrite), .pcWriteCond(pcWriteCond), .pcWriteCondNe(pcWriteCondNe),
    .iorD(iorD), .memRead(memRead), .memWrite(memWrite), .irWrite(irWrite),
    .memToReg(memToReg), .regDst(regDst), .regWrite(regWrite),
    .illegalOp(illegalOp), .state(state)
  );

  main_control #(.HALT_ON_ILLEGAL(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .memReady(memReady),
    .aluOp(aluOp_b), .aluSrcA(aluSrcA_b), .aluSrcB(aluSrcB_b), .pcSrc(pcSrc_b),
    .pcWrite(pcWrite_b), .pcWriteCond(pcWriteCond_b), .pcWriteCondNe(pcWriteCondNe_b),
    .iorD(iorD_b), .memRead(memRead_b), .memWrite(memWrite_b), .irWrite(irWrite_b),
    .memToReg(memToReg_b), .regDst(regDst_b), .regWrite(regWrite_b),
    .illegalOp(illegalOp_b), .state(state_b)
  );

  // Apply one cycle of inputs and queue what the DUTs must show before the next edge.
  task automatic step(input logic [5:0] op, input logic rdy, input logic [3:0] st,
                      input logic [2:0] alu, input logic [15:0] strb, input int st_b = -1);
    exp_t x;
    opcode   = op;
    memReady = rdy;
    x.st   = st;
    x.st_b = (st_b < 0) ? st : st_b[3:0];
    x.alu  = alu;
    x.strb = strb;
    sb.push_back(x);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      e   = sb.pop_front();
      act = {aluSrcA, aluSrcB, pcSrc, pcWrite, pcWriteCond, pcWriteCondNe, iorD,
             memRead, memWrite, irWrite, memToReg, regDst, regWrite, illegalOp};
      n_vec++;
      if (state !== e.st || aluOp !== e.alu || act !== e.strb || state_b !== e.st_b) begin
        n_err++;
        $display("FAIL vec%0d @%0t: got state=%0d aluOp=%b strobes=%h state_b=%0d, want state=%0d aluOp=%b strobes=%h state_b=%0d",
                 n_vec, $time, state, aluOp, act, state_b, e.st, e.alu, e.strb, e.st_b);
      end
    end
  end

  initial begin
    rst_n    = 1'b0;
    opcode   = 6'd0;
    memReady = 1'b0;
    @(posedge clk);
    #1;

    // Reset held, then released: BOOT with no strobes, then FETCH.
    step(6'd0, 1'b1, 4'd0, 3'b000, 16'h0);
    step(6'd0, 1'b1, 4'd0, 3'b000, 16'h0);
    rst_n = 1'b1;
    step(6'd0, 1'b0, 4'd0, 3'b000, 16'h0);

    // lw with one MEMRD stall
    step(6'd35, 1'b1, 4'd1, 3'b000, F_RDY);
    step(6'd35, 1'b1, 4'd2, 3'b000, SRCB_I2);
    step(6'd35, 1'b1, 4'd3, 3'b000, SRCA | SRCB_I);
    step(6'd35, 1'b0, 4'd4, 3'b000, MR | IORD);
    step(6'd35, 1'b1, 4'd4, 3'b000, MR | IORD);
    step(6'd35, 1'b1, 4'd5, 3'b000, RW | M2R);

    // sw with a FETCH stall and three MEMWR wait cycles
    step(6'd43, 1'b0, 4'd1, 3'b000, F_WAIT);
    step(6'd43, 1'b1, 4'd1, 3'b000, F_RDY);
    step(6'd43, 1'b0, 4'd2, 3'b000, SRCB_I2);
    step(6'd43, 1'b1, 4'd3, 3'b000, SRCA | SRCB_I);
    for (int i = 0; i < 3; i++) step(6'd43, 1'b0, 4'd6, 3'b000, MW | IORD);
    step(6'd43, 1'b1, 4'd6, 3'b000, MW | IORD);

    // R-type: funct aluOp during DECODE
    step(6'd0, 1'b1, 4'd1, 3'b000, F_RDY);
    step(6'd0, 1'b1, 4'd2, 3'b010, SRCB_I2);
    step(6'd0, 1'b1, 4'd7, 3'b000, SRCA);
    step(6'd0, 1'b1, 4'd8, 3'b000, RW | RDST);

    // beq and bne
    step(6'd4, 1'b1, 4'd1, 3'b000, F_RDY);
    step(6'd4, 1'b1, 4'd2, 3'b001, SRCB_I2);
    step(6'd4, 1'b1, 4'd9, 3'b000, SRCA | PCS_AO | PCWC);
    step(6'd5, 1'b1, 4'd1, 3'b000, F_RDY);
    step(6'd5, 1'b0, 4'd2, 3'b001, SRCB_I2);
    step(6'd5, 1'b0, 4'd10, 3'b000, SRCA | PCS_AO | PCWN);

    // addi and j, memReady toggled where it must be ignored
    step(6'd8, 1'b1, 4'd1, 3'b000, F_RDY);
    step(6'd8, 1'b0, 4'd2, 3'b000, SRCB_I2);
    step(6'd8, 1'b1, 4'd11, 3'b000, SRCA | SRCB_I);
    step(6'd8, 1'b0, 4'd12, 3'b000, RW);
    step(6'd2, 1'b1, 4'd1, 3'b000, F_RDY);
    step(6'd2, 1'b1, 4'd2, 3'b000, SRCB_I2);
    step(6'd2, 1'b1, 4'd13, 3'b000, PCW | PCS_J);

    // Illegal opcode: one instance parks in HALT, the other returns to FETCH
    step(6'd63, 1'b1, 4'd1, 3'b000, F_RDY);
    step(6'd63, 1'b0, 4'd2, 3'b000, SRCB_I2 | ILL);
    for (int i = 0; i < 20; i++) step(6'd63, 1'b0, 4'd14, 3'b000, 16'h0, 1);

    // Reset mid-HALT takes effect before any clock edge
    rst_n = 1'b0;
    step(6'd0, 1'b1, 4'd0, 3'b000, 16'h0, 0);
    rst_n = 1'b1;
    step(6'd0, 1'b1, 4'd0, 3'b000, 16'h0, 0);
    step(6'd0, 1'b1, 4'd1, 3'b000, F_RDY);
    step(6'd0, 1'b1, 4'd2, 3'b010, SRCB_I2);

    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expected entries never compared, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
